// File: rtl/hamming84_decoder.sv
// hamming84_decoder: two-stage streaming SECDED decoder for the (8,4)
// extended-Hamming codeword {p3,d3,d2,d1,p2,d0,p1,p0}. It is paired with
// saturating counters of SEC and DED words delivered downstream.
module hamming84_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_sec,
    output logic             out_ded,
    output logic [2:0]       out_syndrome,
    input  logic             clr_counts,
    output logic [CNT_W-1:0] sec_count,
    output logic [CNT_W-1:0] ded_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       s1_code_q, s1_code_d;
    logic [2:0]       s1_syn_q, s1_syn_d;
    logic             s1_par_q, s1_par_d;

    logic             s2_valid_q, s2_valid_d;
    logic [3:0]       s2_data_q, s2_data_d;
    logic             s2_sec_q, s2_sec_d;
    logic             s2_ded_q, s2_ded_d;
    logic [2:0]       s2_syn_q, s2_syn_d;

    logic [CNT_W-1:0] sec_count_q, sec_count_d;
    logic [CNT_W-1:0] ded_count_q, ded_count_d;

    logic             s1_load;
    logic             s2_load;
    logic             out_fire;
    logic             syn_zero;
    logic [7:0]       flip_mask;
    logic [7:0]       corrected;

    // A stage may load when it is empty or when the stage after it is moving.
    assign s2_load  = ~s2_valid_q | out_ready;
    assign s1_load  = ~s1_valid_q | s2_load;
    assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;
    assign out_fire = s2_valid_q & out_ready;

    // Stage 1 captures the codeword along with its syndrome and overall parity.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d   = in_code;
                s1_syn_d[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
                s1_syn_d[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
                s1_syn_d[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];
                s1_par_d    = ^in_code;
            end
        end
    end

    // The single-bit correction mask is non-zero only for a correctable in-codeword error.
    // A double error therefore passes the raw bits through unchanged.
    always_comb begin
        syn_zero  = (s1_syn_q == 3'd0);
        flip_mask = 8'h00;
        if (s1_par_q && !syn_zero) begin
            case (s1_syn_q)
                3'd1:    flip_mask = 8'h01;
                3'd2:    flip_mask = 8'h02;
                3'd3:    flip_mask = 8'h04;
                3'd4:    flip_mask = 8'h08;
                3'd5:    flip_mask = 8'h10;
                3'd6:    flip_mask = 8'h20;
                3'd7:    flip_mask = 8'h40;
                default: flip_mask = 8'h00;
            endcase
        end
        corrected = s1_code_q ^ flip_mask;
    end

    // Stage 2 holds the decoded result steady until downstream takes it.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sec_d   = s2_sec_q;
        s2_ded_d   = s2_ded_q;
        s2_syn_d   = s2_syn_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = {corrected[6], corrected[5], corrected[4], corrected[2]};
                s2_sec_d  = s1_par_q;
                s2_ded_d  = ~s1_par_q & ~syn_zero;
                s2_syn_d  = s1_syn_q;
            end
        end
    end

    // The counters saturate and count only delivered words; clear beats increment.
    always_comb begin
        sec_count_d = sec_count_q;
        ded_count_d = ded_count_q;
        if (clr_counts) begin
            sec_count_d = '0;
            ded_count_d = '0;
        end else begin
            if (out_fire && s2_sec_q && sec_count_q != CNT_MAX)
                sec_count_d = sec_count_q + CNT_ONE;
            if (out_fire && s2_ded_q && ded_count_q != CNT_MAX)
                ded_count_d = ded_count_q + CNT_ONE;
        end
    end

    // All pipeline and counter state is registered with an asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= 8'h00;
            s1_syn_q    <= 3'd0;
            s1_par_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= 4'h0;
            s2_sec_q    <= 1'b0;
            s2_ded_q    <= 1'b0;
            s2_syn_q    <= 3'd0;
            sec_count_q <= '0;
            ded_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            s1_syn_q    <= s1_syn_d;
            s1_par_q    <= s1_par_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_sec_q    <= s2_sec_d;
            s2_ded_q    <= s2_ded_d;
            s2_syn_q    <= s2_syn_d;
            sec_count_q <= sec_count_d;
            ded_count_q <= ded_count_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_data     = s2_data_q;
    assign out_sec      = s2_sec_q;
    assign out_ded      = s2_ded_q;
    assign out_syndrome = s2_syn_q;
    assign sec_count    = sec_count_q;
    assign ded_count    = ded_count_q;

endmodule

// File: tb/tb_hamming84_decoder.sv
// tb_hamming84_decoder: table-driven check of the SECDED decoder,
// followed by hand-written backpressure, saturation/clear and reset sequences.
module tb_hamming84_decoder;

    localparam int CNT_W = 4;
    localparam int NVEC  = 12;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_code;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic             out_sec;
    logic             out_ded;
    logic [2:0]       out_syndrome;
    logic             clr_counts;
    logic [CNT_W-1:0] sec_count;
    logic [CNT_W-1:0] ded_count;

    typedef struct {
        logic [7:0] code;
        logic [3:0] data;
        logic       sec;
        logic       ded;
        logic [2:0] syn;
    } vec_t;

    vec_t       vecs [NVEC];
    logic [3:0] got [$];
    logic [3:0] bp_exp [4];
    logic [7:0] bp_words [4];
    logic       collect;
    int         checks;
    int         errors;

    hamming84_decoder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sec      (out_sec),
        .out_ded      (out_ded),
        .out_syndrome (out_syndrome),
        .clr_counts   (clr_counts),
        .sec_count    (sec_count),
        .ded_count    (ded_count)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Record each delivered word while the backpressure sequence is running.
    always @(negedge clk) begin
        if (collect && out_valid && out_ready)
            got.push_back(out_data);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] code);
        in_valid = valid;
        in_code  = code;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Main test sequence.
    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        clr_counts = 1'b0;
        collect = 1'b0;
        checks = 0;
        errors = 0;
        applyStimulus(1'b0, 8'h00);

        vecs[0]  = '{8'h00, 4'h0, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{8'hD2, 4'hA, 1'b0, 1'b0, 3'd0};
        vecs[2]  = '{8'hFF, 4'hF, 1'b0, 1'b0, 3'd0};
        vecs[3]  = '{8'hC2, 4'hA, 1'b1, 1'b0, 3'd5};
        vecs[4]  = '{8'h52, 4'hA, 1'b1, 1'b0, 3'd0};
        vecs[5]  = '{8'hD1, 4'hA, 1'b0, 1'b1, 3'd3};
        vecs[6]  = '{8'h01, 4'h0, 1'b1, 1'b0, 3'd1};
        vecs[7]  = '{8'hBF, 4'hF, 1'b1, 1'b0, 3'd7};
        vecs[8]  = '{8'hF3, 4'hE, 1'b0, 1'b1, 3'd7};
        vecs[9]  = '{8'h08, 4'h0, 1'b1, 1'b0, 3'd4};
        vecs[10] = '{8'h04, 4'h0, 1'b1, 1'b0, 3'd3};
        vecs[11] = '{8'hF2, 4'hA, 1'b1, 1'b0, 3'd6};

        bp_words[0] = 8'h2D; bp_exp[0] = 4'h5;
        bp_words[1] = 8'hD2; bp_exp[1] = 4'hA;
        bp_words[2] = 8'hFF; bp_exp[2] = 4'hF;
        bp_words[3] = 8'h00; bp_exp[3] = 4'h0;

        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_flags", {out_sec, out_ded}, 0);
        checkOutput("rst_syndrome", out_syndrome, 0);
        checkOutput("rst_counts", {sec_count, ded_count}, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        repeat (2) stepCycle();
        rst_n = 1'b1;
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Table vectors, streamed back to back with out_ready high.
        applyStimulus(1'b1, vecs[0].code);
        for (int j = 1; j <= NVEC + 1; j++) begin
            stepCycle();
            if (j >= 2) begin
                checkOutput($sformatf("vec%0d_valid", j - 2), out_valid, 1);
                checkOutput($sformatf("vec%0d_data", j - 2), out_data, vecs[j-2].data);
                checkOutput($sformatf("vec%0d_sec", j - 2), out_sec, vecs[j-2].sec);
                checkOutput($sformatf("vec%0d_ded", j - 2), out_ded, vecs[j-2].ded);
                checkOutput($sformatf("vec%0d_syn", j - 2), out_syndrome, vecs[j-2].syn);
                checkOutput($sformatf("vec%0d_in_ready", j - 2), in_ready, 1);
            end else begin
                checkOutput("latency_not_early", out_valid, 0);
            end
            if (j < NVEC) applyStimulus(1'b1, vecs[j].code);
            else applyStimulus(1'b0, 8'h00);
        end
        stepCycle();
        checkOutput("stream_drained", out_valid, 0);
        checkOutput("stream_sec_count", sec_count, 7);
        checkOutput("stream_ded_count", ded_count, 2);

        // Backpressure: two words fill the pipe, then in_ready drops.
        out_ready = 1'b0;
        applyStimulus(1'b1, bp_words[0]);
        @(negedge clk);
        checkOutput("bp_ready_first", in_ready, 1);
        stepCycle();
        applyStimulus(1'b1, bp_words[1]);
        @(negedge clk);
        checkOutput("bp_ready_second", in_ready, 1);
        stepCycle();
        applyStimulus(1'b1, bp_words[2]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_ready_low", in_ready, 0);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_data_stable", out_data, bp_exp[0]);
            stepCycle();
        end
        out_ready = 1'b1;
        collect = 1'b1;
        stepCycle();
        applyStimulus(1'b1, bp_words[3]);
        stepCycle();
        applyStimulus(1'b0, 8'h00);
        for (int k = 0; k < 20 && got.size() < 4; k++) stepCycle();
        repeat (3) stepCycle();
        collect = 1'b0;
        checkOutput("bp_word_count", got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) checkOutput($sformatf("bp_order%0d", k), got[k], bp_exp[k]);
            else checkOutput($sformatf("bp_missing%0d", k), 1, 0);
        end

        // Saturation: 20 SEC words on top of the 7 already counted.
        applyStimulus(1'b1, 8'hC2);
        repeat (20) stepCycle();
        applyStimulus(1'b0, 8'h00);
        repeat (3) stepCycle();
        checkOutput("sat_sec_count", sec_count, 15);
        checkOutput("sat_ded_count", ded_count, 2);

        clr_counts = 1'b1;
        stepCycle();
        clr_counts = 1'b0;
        checkOutput("clr_counts_zero", {sec_count, ded_count}, 0);

        // Clear in the same cycle as an SEC transfer wins over the increment.
        applyStimulus(1'b1, 8'hC2);
        stepCycle();
        applyStimulus(1'b0, 8'h00);
        stepCycle();
        checkOutput("clr_race_sec_present", {out_valid, out_sec}, 2'b11);
        clr_counts = 1'b1;
        stepCycle();
        clr_counts = 1'b0;
        checkOutput("clr_race_count", sec_count, 0);
        checkOutput("clr_race_drained", out_valid, 0);

        applyStimulus(1'b1, 8'hC2);
        stepCycle();
        applyStimulus(1'b0, 8'h00);
        repeat (2) stepCycle();
        checkOutput("sec_count_one", sec_count, 1);

        // Reset in mid-stream clears outputs and counters immediately.
        applyStimulus(1'b1, 8'hBF);
        repeat (3) stepCycle();
        checkOutput("pre_rst_valid", out_valid, 1);
        checkOutput("pre_rst_count_nonzero", sec_count != 0, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_out_data", out_data, 0);
        checkOutput("mid_rst_flags", {out_sec, out_ded, out_syndrome}, 0);
        checkOutput("mid_rst_counts", {sec_count, ded_count}, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        applyStimulus(1'b0, 8'h00);
        stepCycle();
        rst_n = 1'b1;
        repeat (2) stepCycle();
        checkOutput("post_rst_no_leftover", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
